gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of independent GPIO channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2, input synchroniser depth (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required before an input change is accepted (>=1).
REQ-004 clk  input  1  single block clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 dir_we  input  1  when high, load dir_wdata into the direction register.
REQ-007 dir_wdata  input  WIDTH  direction write data; per bit, 1 = output, 0 = input.
REQ-008 outpad  input  WIDTH  core-side output data.
REQ-009 pad_in  input  WIDTH  raw asynchronous value from the pad cells.
REQ-010 pad_out  output  WIDTH  registered output data to the pad cells.
REQ-011 pad_oe  output  WIDTH  pad tri-state enable; equals the direction register.
REQ-012 inpad  output  WIDTH  synchronised, debounced pad value to the core.
REQ-013 rise_en / fall_en  input  WIDTH each  per-channel interrupt enable for rising / falling accepted edges.
REQ-014 irq_clr  input  WIDTH  write-1-to-clear for irq_status bits.
REQ-015 rise / fall  output  WIDTH each  one-cycle pulses on accepted edges of inpad.
REQ-016 irq_status  output  WIDTH  sticky per-channel interrupt flags.
REQ-017 irq  output  1  OR-reduction of irq_status.

Function
REQ-018 The direction register SHALL take dir_wdata on the first clock edge with dir_we=1; pad_oe SHALL be that register.
REQ-019 pad_out SHALL register outpad every cycle (1-cycle latency), independent of direction.
REQ-020 Each pad_in bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-021 Per channel, the debouncer SHALL hold a stable value and a counter; the counter increments while the synchronised value differs from the stable value and clears to 0 on any cycle they match.
REQ-022 The stable value SHALL flip on the edge at which the counter reaches DEBOUNCE_CYCLES, and the counter SHALL clear on that edge; total latency from the first edge sampling a new pad level is SYNC_STAGES+DEBOUNCE_CYCLES edges.
REQ-023 inpad SHALL equal the stable value for input channels (dir=0).
REQ-024 For output channels (dir=1), inpad SHALL be 0, the stable value and counter SHALL be held at 0, and no edges SHALL be reported.
REQ-025 Switching a channel from output to input SHALL start debouncing from stable=0; a high pad then yields a normal rising edge after DEBOUNCE_CYCLES.
REQ-026 rise (fall) SHALL pulse for exactly one cycle, the cycle after stable goes 0->1 (1->0).
REQ-027 irq_status[i] SHALL set on (rise[i]&rise_en[i]) | (fall[i]&fall_en[i]) and clear on irq_clr[i]; simultaneous set and clear SHALL leave it set.
REQ-028 The counter SHALL saturate and never wrap; width is clog2(DEBOUNCE_CYCLES+1).

Reset
REQ-029 On rst_n low, asynchronously: direction register, pad_out, synchroniser flops, counters, stable values, rise, fall and irq_status SHALL be 0; hence pad_oe=0, inpad=0, irq=0.
REQ-030 Reset asserted mid-debounce SHALL discard the pending change; after release, channels restart from stable=0.

Structure
REQ-031 Package gpio_bank_pkg SHALL hold the counter-width function and the direction encoding constants (DIR_IN=0, DIR_OUT=1).
REQ-032 Per-channel synchroniser, debouncer and edge detector SHALL live in sub-module gpio_debounce, instantiated WIDTH times by generate.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3)
REQ-033 Reset with pad_in=4'hF -> pad_oe=0, pad_out=0, inpad=0, irq=0 throughout reset.
REQ-034 dir_we=1, dir_wdata=4'b0101, outpad=4'hF -> next edge pad_oe=4'b0101, pad_out=4'hF; inpad[0], inpad[2] stay 0.
REQ-035 Channel 1 input, rise_en=4'b0010; pad_in[1] 0->1 held -> inpad[1]=1 exactly 5 edges later, rise[1] one-cycle pulse, irq_status=4'b0010, irq=1.
REQ-036 pad_in[3] high for 2 cycles then low -> inpad[3], rise[3], irq_status[3] remain 0.
REQ-037 irq_clr[1]=1 in the same cycle a new enabled edge sets irq_status[1] -> irq_status[1] stays 1; irq_clr[1] alone next cycle -> 0.
REQ-038 rst_n pulsed low 2 cycles into debouncing a 0->1 on channel 2 with pad held high -> inpad[2]=0 immediately; rise[2] occurs 5 edges after release.

Source files
------------

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO bank: direction encoding and debounce counter sizing.
package gpio_bank_pkg;

  // Direction register encoding, per channel
  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  // Bits needed to hold a debounce count of 0..n inclusive
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// Core-side bus of the GPIO bank; the bank itself is the slave.
interface gpio_bank_if #(
  parameter int WIDTH = 8
);
  logic             dir_we;
  logic [WIDTH-1:0] dir_wdata;
  logic [WIDTH-1:0] outpad;
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] pad_out;
  logic [WIDTH-1:0] pad_oe;
  logic [WIDTH-1:0] inpad;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] irq_status;
  logic             irq;

  modport slave (
    input  dir_we, dir_wdata, outpad, pad_in, rise_en, fall_en, irq_clr,
    output pad_out, pad_oe, inpad, rise, fall, irq_status, irq
  );

  modport master (
    output dir_we, dir_wdata, outpad, pad_in, rise_en, fall_en, irq_clr,
    input  pad_out, pad_oe, inpad, rise, fall, irq_status, irq
  );
endinterface

// File: rtl/gpio_debounce.sv
// One GPIO channel: pad synchroniser, debouncer with saturating counter, edge pulses.
module gpio_debounce
  import gpio_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  input  logic i_dir,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);
  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Shift the raw pad level through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
  end

  // Accept a new level only after it has differed from the stable value long enough;
  // output channels are parked at 0 so a later switch to input starts clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_dir == DIR_OUT) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_synced == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_LAST) begin
        // This edge is the one on which the count reaches its target
        r_stable <= w_synced;
        r_cnt    <= '0;
        r_rise   <= w_synced;
        r_fall   <= ~w_synced;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
endmodule

// File: rtl/gpio_bank.sv
// GPIO bank: direction and output registers, per-channel input conditioning, sticky interrupts.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  gpio_bank_if.slave bus
);
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_pad_out;
  logic [WIDTH-1:0] r_irq_status;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_irq_set;

  // Direction register loads on write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_dir <= '0;
    else if (bus.dir_we) r_dir <= bus.dir_wdata;
  end

  // Output data is registered every cycle regardless of direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pad_out <= '0;
    else        r_pad_out <= bus.outpad;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      gpio_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pad    (bus.pad_in[gi]),
        .i_dir    (r_dir[gi]),
        .o_stable (w_stable[gi]),
        .o_rise   (w_rise[gi]),
        .o_fall   (w_fall[gi])
      );
    end
  endgenerate

  assign w_irq_set = (w_rise & bus.rise_en) | (w_fall & bus.fall_en);

  // Sticky flags: a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_status <= '0;
    else        r_irq_status <= (r_irq_status & ~bus.irq_clr) | w_irq_set;
  end

  assign bus.pad_oe     = r_dir;
  assign bus.pad_out    = r_pad_out;
  // The stable value can still be 1 on the cycle a channel turns to output
  assign bus.inpad      = w_stable & ~r_dir;
  assign bus.rise       = w_rise;
  assign bus.fall       = w_fall;
  assign bus.irq_status = r_irq_status;
  assign bus.irq        = |r_irq_status;
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: behavioural model compared every cycle plus directed literal checks.
module tb_gpio_bank;
  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gpio_bank_if #(.WIDTH(W)) bus ();

  gpio_bank #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pad history: the debouncer at an edge sees the pad level sampled SYNC edges earlier
  logic [W-1:0] hist[$];
  logic [W-1:0] m_dir = '0, m_pad_out = '0, m_stable = '0;
  logic [W-1:0] m_rise = '0, m_fall = '0, m_irq = '0;
  int           m_run[W];

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] old_dir, synced;
    if (!rst_n) begin
      m_dir = '0; m_pad_out = '0; m_stable = '0;
      m_rise = '0; m_fall = '0; m_irq = '0;
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back('0);
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      old_dir = m_dir;
      m_irq = (m_irq & ~bus.irq_clr) | (m_rise & bus.rise_en) | (m_fall & bus.fall_en);
      synced = hist.pop_front();
      hist.push_back(bus.pad_in);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (old_dir[i]) begin
          m_stable[i] = 1'b0;
          m_run[i] = 0;
        end else if (synced[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin
            m_stable[i] = synced[i];
            m_run[i] = 0;
            if (synced[i]) m_rise[i] = 1'b1;
            else           m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pad_out = bus.outpad;
      if (bus.dir_we) m_dir = bus.dir_wdata;
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("m_pad_oe",     bus.pad_oe,     m_dir);
    chk("m_pad_out",    bus.pad_out,    m_pad_out);
    chk("m_inpad",      bus.inpad,      m_stable & ~m_dir);
    chk("m_rise",       bus.rise,       m_rise);
    chk("m_fall",       bus.fall,       m_fall);
    chk("m_irq_status", bus.irq_status, m_irq);
    chk("m_irq",        bus.irq,        |m_irq);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed scenario ----------------
  initial begin
    rst_n = 1'b0;
    bus.dir_we = 1'b0; bus.dir_wdata = '0; bus.outpad = '0;
    bus.pad_in = 4'hF; bus.rise_en = '0; bus.fall_en = '0; bus.irq_clr = '0;

    // reset with pads high
    repeat (3) begin
      step();
      chk("rst_pad_oe", bus.pad_oe, 4'h0);
      chk("rst_pad_out", bus.pad_out, 4'h0);
      chk("rst_inpad", bus.inpad, 4'h0);
      chk("rst_irq", bus.irq, 1'b0);
    end
    bus.pad_in = 4'h0;
    rst_n = 1'b1;
    step();

    // direction write and output data
    bus.dir_we = 1'b1; bus.dir_wdata = 4'b0101; bus.outpad = 4'hF;
    step();
    $display("dir write: pad_oe=%b pad_out=%h", bus.pad_oe, bus.pad_out);
    chk("dir_pad_oe", bus.pad_oe, 4'b0101);
    chk("dir_pad_out", bus.pad_out, 4'hF);
    bus.dir_we = 1'b0;
    bus.pad_in = 4'b0101;
    repeat (6) step();
    chk("out_ch_inpad", bus.inpad & 4'b0101, 4'h0);

    // rising edge on input channel 1
    bus.rise_en = 4'b0010;
    bus.pad_in = 4'b0111;
    repeat (4) step();
    chk("ch1_before", bus.inpad[1], 1'b0);
    step();
    $display("ch1 rise: inpad=%b rise=%b", bus.inpad, bus.rise);
    chk("ch1_inpad", bus.inpad[1], 1'b1);
    chk("ch1_rise", bus.rise, 4'b0010);
    chk("ch1_irq_pre", bus.irq_status, 4'b0000);
    step();
    chk("ch1_rise_end", bus.rise, 4'b0000);
    chk("ch1_irq_status", bus.irq_status, 4'b0010);
    chk("ch1_irq", bus.irq, 1'b1);

    // glitch on channel 3 shorter than debounce window
    bus.rise_en = 4'b1010;
    bus.pad_in = 4'b1111;
    repeat (2) step();
    bus.pad_in = 4'b0111;
    repeat (8) step();
    $display("ch3 glitch: inpad=%b irq_status=%b", bus.inpad, bus.irq_status);
    chk("ch3_inpad", bus.inpad[3], 1'b0);
    chk("ch3_irq_status", bus.irq_status, 4'b0010);

    // clear, then simultaneous set+clear
    bus.irq_clr = 4'b0010;
    step();
    bus.irq_clr = 4'b0000;
    chk("clr_irq_status", bus.irq_status, 4'b0000);
    chk("clr_irq", bus.irq, 1'b0);
    bus.fall_en = 4'b0010;
    bus.pad_in = 4'b0101;
    repeat (5) step();
    chk("ch1_fall", bus.fall, 4'b0010);
    bus.irq_clr = 4'b0010;
    step();
    $display("set+clr: irq_status=%b", bus.irq_status);
    chk("setclr_irq_status", bus.irq_status, 4'b0010);
    step();
    chk("clr_only_irq_status", bus.irq_status, 4'b0000);
    bus.irq_clr = 4'b0000;

    // channel 2 to input, then reset mid-debounce
    bus.pad_in = 4'b0001;
    bus.dir_we = 1'b1; bus.dir_wdata = 4'b0001;
    step();
    bus.dir_we = 1'b0;
    repeat (4) step();
    bus.pad_in = 4'b0101;
    repeat (4) step();
    chk("ch2_pending", bus.inpad[2], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_inpad", bus.inpad, 4'h0);
    chk("midrst_irq", bus.irq, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    repeat (4) step();
    chk("ch2_rise_early", bus.rise[2], 1'b0);
    chk("ch2_inpad_early", bus.inpad[2], 1'b0);
    step();
    $display("post-reset ch2: inpad=%b rise=%b", bus.inpad, bus.rise);
    chk("ch2_rise", bus.rise[2], 1'b1);
    chk("ch2_inpad", bus.inpad[2], 1'b1);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
